// File: rtl/bram_reader.sv
// ---------------------------------------------------------------------------
// bram_reader
//
// Reads a contiguous run of cells from a BRAM1-style memory (combinational
// read, DOUT = mem[ADDR]) and presents them as a ready/valid stream with a
// last-beat marker. The memory is only ever read: WR and DIN are tied off.
//
// Ports
//   CLK     in   clock, all state changes on the rising edge
//   RST     in   asynchronous active-high reset
//   START   in   begin a burst (honoured only in IDLE)
//   BASE    in   first cell address, sampled with START
//   COUNT   in   cells to read, sampled with START; 0 = empty burst
//   BUSY    out  high whenever a burst is in progress
//   DONE    out  one-cycle pulse when a burst (including an empty one) ends
//   MADDR   out  memory address
//   MWR     out  memory write enable, always 0
//   MDIN    out  memory write data, always 0
//   MDOUT   in   memory read data for MADDR
//   TVALID  out  stream beat valid
//   TDATA   out  stream beat data
//   TLAST   out  final beat of the burst
//   TREADY  in   downstream accepts when TVALID && TREADY
//
// The address and count registers are as wide as the Ncells parameter
// itself, so a burst may be longer than the memory; the address simply
// wraps from Ncells-1 back to 0 and re-reads cells.
// ---------------------------------------------------------------------------
module bram_reader #(
  parameter int Ncells = 1_024,
  parameter int Wdata  = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  input  logic [$bits(Ncells)-1:0]  BASE,
  input  logic [$bits(Ncells)-1:0]  COUNT,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [$bits(Ncells)-1:0]  MADDR,
  output logic                      MWR,
  output logic [Wdata-1:0]          MDIN,
  input  logic [Wdata-1:0]          MDOUT,
  output logic                      TVALID,
  output logic [Wdata-1:0]          TDATA,
  output logic                      TLAST,
  input  logic                      TREADY
);

  localparam int AW = $bits(Ncells);
  localparam logic [AW-1:0] LAST_ADDR = AW'(Ncells - 1);
  localparam logic [AW-1:0] ONE       = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             state_reg,  state_next;
  logic [AW-1:0]      addr_reg,   addr_next;
  logic [AW-1:0]      cnt_reg,    cnt_next;
  logic [Wdata-1:0]   tdata_reg,  tdata_next;
  logic               tvalid_reg, tvalid_next;
  logic               tlast_reg,  tlast_next;
  logic               done_reg,   done_next;

  // The output register can take a new beat when it is empty or its
  // current beat is leaving this cycle.
  logic capture;
  logic accept;

  always_comb begin
    capture = (state_reg == S_READ) && (!tvalid_reg || TREADY);
    accept  = tvalid_reg && TREADY;
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    cnt_next    = cnt_reg;
    tdata_next  = tdata_reg;
    tvalid_next = tvalid_reg;
    tlast_next  = tlast_reg;
    done_next   = 1'b0;

    // An accepted beat empties the output register unless a capture below
    // refills it in the same cycle.
    if (accept) begin
      tvalid_next = 1'b0;
      tlast_next  = 1'b0;
    end

    case (state_reg)
      S_IDLE: begin
        if (START) begin
          if (COUNT != '0) begin
            addr_next  = BASE;
            cnt_next   = COUNT;
            state_next = S_READ;
          end else begin
            // Empty burst: finish without ever leaving IDLE.
            done_next = 1'b1;
          end
        end
      end

      S_READ: begin
        if (capture) begin
          tdata_next  = MDOUT;
          tvalid_next = 1'b1;
          tlast_next  = (cnt_reg == ONE);
          addr_next   = (addr_reg == LAST_ADDR) ? '0 : addr_reg + ONE;
          cnt_next    = cnt_reg - ONE;
          if (cnt_reg == ONE) begin
            state_next = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        // Only the TLAST beat can be pending here.
        if (accept) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= S_IDLE;
      addr_reg   <= '0;
      cnt_reg    <= '0;
      tdata_reg  <= '0;
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      cnt_reg    <= cnt_next;
      tdata_reg  <= tdata_next;
      tvalid_reg <= tvalid_next;
      tlast_reg  <= tlast_next;
      done_reg   <= done_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    BUSY   = (state_reg != S_IDLE);
    DONE   = done_reg;
    MADDR  = addr_reg;
    MWR    = 1'b0;
    MDIN   = '0;
    TVALID = tvalid_reg;
    TDATA  = tdata_reg;
    TLAST  = tlast_reg;
  end

endmodule

// File: doc/bram_reader.md
BRAM_READER -- requirements
Module: bram_reader

Interface
REQ-001 Parameter Ncells, default 1_024, number of cells in the attached BRAM1-style memory.
REQ-002 Parameter Wdata, default 8, width of one memory cell and of the stream data.
REQ-003 CLK  input  1  the only clock; all state changes on the rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 START  input  1  when high in IDLE, begin a burst using BASE and COUNT.
REQ-006 BASE  input  $bits(Ncells)  first cell address, sampled with START.
REQ-007 COUNT  input  $bits(Ncells)  number of cells to read, sampled with START; 0 means an empty burst.
REQ-008 BUSY  output  1  high whenever not in IDLE.
REQ-009 DONE  output  1  one-cycle pulse when a burst completes.
REQ-010 MADDR  output  $bits(Ncells)  address to the memory ADDR port.
REQ-011 MWR  output  1  memory WR; constant 0.
REQ-012 MDIN  output  Wdata  memory DIN; constant 0.
REQ-013 MDOUT  input  Wdata  memory DOUT, combinational read of mem[MADDR].
REQ-014 TVALID  output  1  stream beat valid.
REQ-015 TDATA  output  Wdata  stream beat data.
REQ-016 TLAST  output  1  marks the final beat of a burst.
REQ-017 TREADY  input  1  downstream accepts the beat when TVALID and TREADY are both high.

Function
REQ-018 States IDLE, READ and DRAIN, held in a state register.
REQ-019 IDLE: START=1 with COUNT>0 latches the address register from BASE and the remaining-count register from COUNT, then moves to READ.
REQ-020 IDLE: START=1 with COUNT=0 stays in IDLE, pulses DONE in the next cycle and emits no beat.
REQ-021 START is ignored while BUSY=1; in-flight BASE and COUNT are unaffected.
REQ-022 MADDR equals the address register in every state.
REQ-023 READ capture condition: the output register is free, i.e. TVALID=0 or TREADY=1 in the same cycle.
REQ-024 READ with the capture condition true: at the next edge the block loads TDATA from MDOUT, sets TVALID=1, increments the address and decrements the remaining count.
REQ-025 The address wraps from Ncells-1 to 0.
REQ-026 TLAST is set with the beat whose remaining count was 1 at capture; the state then moves READ->DRAIN.
REQ-027 READ with the capture condition false: state, address, count, TDATA and TLAST hold.
REQ-028 While TVALID=1 and TREADY=0, TDATA and TLAST hold stable and TVALID stays high.
REQ-029 DRAIN: when the TLAST beat is accepted, TVALID clears, the state moves to IDLE and DONE pulses in the following cycle.
REQ-030 A TREADY=1 handshake with no new capture clears TVALID.
REQ-031 Latency: START at edge n gives the first TVALID after edge n+2.
REQ-032 With TREADY held high, throughput is one beat per cycle; a burst of N cells completes in N+2 cycles from START.
REQ-033 Burst length ranges from 1 to 2^$bits(Ncells)-1; bursts longer than Ncells re-read cells after wrap.

Reset
REQ-034 RST=1 immediately forces IDLE and clears BUSY, DONE, TVALID, TLAST, TDATA, MADDR, and the address and count registers, independent of CLK.
REQ-035 Reset during READ or DRAIN aborts the burst: no DONE pulse, and any pending beat is discarded.
REQ-036 After RST deasserts, the block accepts START on the first rising edge.

Verification
REQ-037 Memory mem[i]=i+8'h10; BASE=4, COUNT=3, TREADY=1 -> beats 14,15,16 on consecutive cycles, TLAST on 16, DONE once, BUSY low after.
REQ-038 Ncells=16, BASE=14, COUNT=4 -> beats read addresses 14,15,0,1 with TLAST on address 1.
REQ-039 BASE=0, COUNT=2, TREADY low for 3 cycles after the first TVALID -> TDATA stays mem[0] throughout, then mem[0] and mem[1] are accepted in order, with no loss and no duplication.
REQ-040 START with COUNT=0 -> TVALID never rises and DONE pulses exactly once one cycle later.
REQ-041 START pulsed again mid-burst with different BASE -> ignored; original sequence completes unchanged.
REQ-042 RST asserted between edges during the second beat of a COUNT=5 burst -> TVALID and BUSY low immediately, no DONE; a fresh burst afterwards behaves as in REQ-037.
